rpn_evaluator: RTL



---
 rtl/plotter_pkg.sv | 54 +++++
 rtl/fixed_point_divider.sv | 70 +++++++
 rtl/rpn_evaluator.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plotter_pkg.sv
// Shared plotter definitions: token opcodes, evaluator error codes, evaluator states and the
// result narrowing helper (clamps when RPN_EVALUATOR_SATURATE_EN is defined, wraps otherwise).
package plotter_pkg;

   localparam logic [2:0] OP_PLUS         = 3'd0;
   localparam logic [2:0] OP_SUB          = 3'd1;
   localparam logic [2:0] OP_MUL          = 3'd2;
   localparam logic [2:0] OP_DIV          = 3'd3;
   localparam logic [2:0] OP_POW          = 3'd4;
   localparam logic [2:0] OP_LEFT_BRACKET = 3'd5;
   localparam logic [2:0] OP_VAR          = 3'd6;

   localparam logic [2:0] ERR_NONE       = 3'd0;
   localparam logic [2:0] ERR_UNDERFLOW  = 3'd1;
   localparam logic [2:0] ERR_OVERFLOW   = 3'd2;
   localparam logic [2:0] ERR_DIV_ZERO   = 3'd3;
   localparam logic [2:0] ERR_ILLEGAL_OP = 3'd4;
   localparam logic [2:0] ERR_DEPTH      = 3'd5;
   localparam logic [2:0] ERR_NEG_EXP    = 3'd6;

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StWait,
      StExec,
      StDivide,
      StPower,
      StFinish,
      StError,
      StDone
   } state_e;

   localparam int unsigned WIDE_W = 64;
   typedef logic signed [WIDE_W-1:0] wide_t;

   // Returns v reduced to a w-bit signed range, sign-extended back to WIDE_W bits.
   function automatic wide_t narrow(input wide_t v, input int unsigned w);
`ifdef RPN_EVALUATOR_SATURATE_EN
      wide_t max_v;
      wide_t min_v;
      max_v = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
      min_v = ~max_v;
      if (v > max_v) begin
         return max_v;
      end else if (v < min_v) begin
         return min_v;
      end
      return v;
`else
      return (v <<< (WIDE_W - w)) >>> (WIDE_W - w);
`endif
   endfunction

endpackage

// File: rtl/fixed_point_divider.sv
// Sequential restoring divider: quotient = (|dividend| << FRACTIONAL_PART_WIDTH) / |divisor|,
// one quotient bit per cycle, sign applied afterwards (truncates toward zero).
module fixed_point_divider #(
   parameter int unsigned NUMBER_WIDTH          = 16,
   parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
   localparam int unsigned Q_W = NUMBER_WIDTH + FRACTIONAL_PART_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic signed [NUMBER_WIDTH-1:0] dividend,
   input  logic signed [NUMBER_WIDTH-1:0] divisor,
   output logic                           done,
   output logic signed [Q_W:0]            quotient
);

   localparam int unsigned CNT_W = $clog2(Q_W + 1);

   logic                    busy_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [Q_W-1:0]          quo_q;
   logic [NUMBER_WIDTH-1:0] rem_q;
   logic [NUMBER_WIDTH-1:0] dvs_q;
   logic                    neg_q;

   logic [NUMBER_WIDTH-1:0] mag_a;
   logic [NUMBER_WIDTH-1:0] mag_b;
   logic [NUMBER_WIDTH:0]   rem_shift;
   logic                    fits;
   logic [NUMBER_WIDTH-1:0] rem_next;
   logic [Q_W:0]            quo_ext;

   assign mag_a = dividend[NUMBER_WIDTH-1] ? (~dividend + 1'b1) : dividend;
   assign mag_b = divisor[NUMBER_WIDTH-1] ? (~divisor + 1'b1) : divisor;

   // quo_q doubles as the dividend shift register; quotient bits enter at the bottom.
   assign rem_shift = {rem_q, quo_q[Q_W-1]};
   assign fits      = rem_shift >= {1'b0, dvs_q};
   assign rem_next  = fits ? NUMBER_WIDTH'(rem_shift - {1'b0, dvs_q})
                           : rem_shift[NUMBER_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         neg_q  <= 1'b0;
      end else if (start) begin
         busy_q <= 1'b1;
         cnt_q  <= CNT_W'(Q_W);
         quo_q  <= Q_W'(mag_a) << FRACTIONAL_PART_WIDTH;
         rem_q  <= '0;
         dvs_q  <= mag_b;
         neg_q  <= dividend[NUMBER_WIDTH-1] ^ divisor[NUMBER_WIDTH-1];
      end else if (busy_q && (cnt_q != '0)) begin
         rem_q <= rem_next;
         quo_q <= {quo_q[Q_W-2:0], fits};
         cnt_q <= cnt_q - CNT_W'(1);
      end else if (busy_q) begin
         busy_q <= 1'b0;
      end
   end

   assign done     = busy_q && (cnt_q == '0);
   assign quo_ext  = {1'b0, quo_q};
   assign quotient = neg_q ? -quo_ext : quo_ext;

endmodule

// File: rtl/rpn_evaluator.sv
// Evaluates the parser's postfix token queue for one value of x on a fixed-point operand stack.
// Overflowing results wrap by default and clamp when RPN_EVALUATOR_SATURATE_EN is defined.
module rpn_evaluator
   import plotter_pkg::*;
#(
   parameter int unsigned INTEGER_PART_WIDTH    = 8,
   parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
   parameter int unsigned OUTPUT_QUEUE_SIZE     = 64,
   parameter int unsigned STACK_SIZE            = 16,
   localparam int unsigned NUMBER_WIDTH       = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH,
   localparam int unsigned OUTPUT_VALUE_WIDTH = NUMBER_WIDTH + 1,
   localparam int unsigned IDX_W              = $clog2(OUTPUT_QUEUE_SIZE) + 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [NUMBER_WIDTH-1:0]       x,
   input  logic [IDX_W-1:0]              expr_length,
   output logic                          queue_rd_en,
   output logic [IDX_W-1:0]              queue_rd_index,
   input  logic [OUTPUT_VALUE_WIDTH-1:0] queue_rd_data,
   input  logic                          queue_rd_valid,
   output logic                          busy,
   output logic                          done,
   output logic [NUMBER_WIDTH-1:0]       result,
   output logic                          error,
   output logic [2:0]                    error_code
);

   localparam int unsigned SP_W   = $clog2(STACK_SIZE + 1);
   localparam int unsigned STK_AW = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;
   localparam int unsigned DIV_W  = NUMBER_WIDTH + FRACTIONAL_PART_WIDTH;
   localparam int unsigned NW     = NUMBER_WIDTH;

   typedef logic signed [NW-1:0] num_t;

   localparam num_t ONE = num_t'(1) <<< FRACTIONAL_PART_WIDTH;

   function automatic num_t fit(input wide_t v);
      return num_t'(narrow(v, NW));
   endfunction

   state_e                        state_q, state_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [IDX_W-1:0]              len_q, len_d;
   logic [SP_W-1:0]               sp_q, sp_d;
   num_t                          x_q, x_d;
   logic [OUTPUT_VALUE_WIDTH-1:0] tok_q, tok_d;
   num_t                          pow_base_q, pow_base_d;
   num_t                          pow_acc_q, pow_acc_d;
   logic [INTEGER_PART_WIDTH-1:0] pow_cnt_q, pow_cnt_d;
   logic [2:0]                    err_pend_q, err_pend_d;
   num_t                          result_q, result_d;
   logic                          error_q, error_d;
   logic [2:0]                    code_q, code_d;

   num_t             stack_q [STACK_SIZE];
   logic             push_en;
   logic [STK_AW-1:0] push_addr;
   num_t             push_val;

   logic [SP_W-1:0]  sp_m1, sp_m2;
   num_t             op_a, op_b;
   logic [2:0]       opcode;
   logic             stack_full;

   logic signed [NW:0]          sum, diff;
   logic signed [2*NW-1:0]      prod_ab, prod_pow;
   logic                        div_start, div_done;
   logic signed [DIV_W:0]       div_q;

   // b is the stack top, a the entry beneath it.
   assign sp_m1      = sp_q - SP_W'(1);
   assign sp_m2      = sp_q - SP_W'(2);
   assign op_b       = stack_q[sp_m1[STK_AW-1:0]];
   assign op_a       = stack_q[sp_m2[STK_AW-1:0]];
   assign opcode     = tok_q[2:0];
   assign stack_full = sp_q == SP_W'(STACK_SIZE);

   assign sum      = {op_a[NW-1], op_a} + {op_b[NW-1], op_b};
   assign diff     = {op_a[NW-1], op_a} - {op_b[NW-1], op_b};
   assign prod_ab  = $signed({{NW{op_a[NW-1]}}, op_a}) * $signed({{NW{op_b[NW-1]}}, op_b});
   assign prod_pow = $signed({{NW{pow_acc_q[NW-1]}}, pow_acc_q})
                   * $signed({{NW{pow_base_q[NW-1]}}, pow_base_q});

   fixed_point_divider #(
      .NUMBER_WIDTH         (NW),
      .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH)
   ) u_divider (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (div_start),
      .dividend(op_a),
      .divisor (op_b),
      .done    (div_done),
      .quotient(div_q)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      sp_d        = sp_q;
      x_d         = x_q;
      tok_d       = tok_q;
      pow_base_d  = pow_base_q;
      pow_acc_d   = pow_acc_q;
      pow_cnt_d   = pow_cnt_q;
      err_pend_d  = err_pend_q;
      result_d    = result_q;
      error_d     = error_q;
      code_d      = code_q;
      push_en     = 1'b0;
      push_addr   = sp_q[STK_AW-1:0];
      push_val    = '0;
      div_start   = 1'b0;
      queue_rd_en = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               x_d     = x;
               len_d   = expr_length;
               sp_d    = '0;
               idx_d   = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (idx_q == len_q) begin
               state_d = StFinish;
            end else begin
               queue_rd_en = 1'b1;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (queue_rd_valid) begin
               tok_d   = queue_rd_data;
               state_d = StExec;
            end
         end
         StExec: begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StFetch;
            if (!tok_q[NW] || (opcode == OP_VAR)) begin
               if (stack_full) begin
                  err_pend_d = ERR_OVERFLOW;
                  state_d    = StError;
               end else begin
                  push_en  = 1'b1;
                  push_val = tok_q[NW] ? x_q : tok_q[NW-1:0];
                  sp_d     = sp_q + SP_W'(1);
               end
            end else if ((opcode == OP_LEFT_BRACKET) || (opcode == 3'd7)) begin
               err_pend_d = ERR_ILLEGAL_OP;
               state_d    = StError;
            end else if (sp_q < SP_W'(2)) begin
               err_pend_d = ERR_UNDERFLOW;
               state_d    = StError;
            end else begin
               // Two-operand results overwrite a; sp drops by one when the result lands.
               push_addr = sp_m2[STK_AW-1:0];
               case (opcode)
                  OP_PLUS: begin
                     push_en  = 1'b1;
                     push_val = fit(wide_t'(sum));
                     sp_d     = sp_m1;
                  end
                  OP_SUB: begin
                     push_en  = 1'b1;
                     push_val = fit(wide_t'(diff));
                     sp_d     = sp_m1;
                  end
                  OP_MUL: begin
                     push_en  = 1'b1;
                     push_val = fit(wide_t'(prod_ab >>> FRACTIONAL_PART_WIDTH));
                     sp_d     = sp_m1;
                  end
                  OP_DIV: begin
                     if (op_b == '0) begin
                        err_pend_d = ERR_DIV_ZERO;
                        state_d    = StError;
                     end else begin
                        div_start = 1'b1;
                        state_d   = StDivide;
                     end
                  end
                  default: begin
                     if (op_b[NW-1]) begin
                        err_pend_d = ERR_NEG_EXP;
                        state_d    = StError;
                     end else begin
                        pow_base_d = op_a;
                        pow_acc_d  = ONE;
                        pow_cnt_d  = op_b[NW-1:FRACTIONAL_PART_WIDTH];
                        state_d    = StPower;
                     end
                  end
               endcase
            end
         end
         StDivide: begin
            if (div_done) begin
               push_en   = 1'b1;
               push_addr = sp_m2[STK_AW-1:0];
               push_val  = fit(wide_t'(div_q));
               sp_d      = sp_m1;
               state_d   = StFetch;
            end
         end
         StPower: begin
            if (pow_cnt_q == '0) begin
               push_en   = 1'b1;
               push_addr = sp_m2[STK_AW-1:0];
               push_val  = pow_acc_q;
               sp_d      = sp_m1;
               state_d   = StFetch;
            end else begin
               pow_acc_d = fit(wide_t'(prod_pow >>> FRACTIONAL_PART_WIDTH));
               pow_cnt_d = pow_cnt_q - INTEGER_PART_WIDTH'(1);
            end
         end
         StFinish: begin
            if (sp_q == SP_W'(1)) begin
               result_d = stack_q[0];
               error_d  = 1'b0;
               code_d   = ERR_NONE;
               state_d  = StDone;
            end else begin
               err_pend_d = ERR_DEPTH;
               state_d    = StError;
            end
         end
         StError: begin
            result_d = '0;
            error_d  = 1'b1;
            code_d   = err_pend_q;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         len_q      <= '0;
         sp_q       <= '0;
         x_q        <= '0;
         tok_q      <= '0;
         pow_base_q <= '0;
         pow_acc_q  <= '0;
         pow_cnt_q  <= '0;
         err_pend_q <= ERR_NONE;
         result_q   <= '0;
         error_q    <= 1'b0;
         code_q     <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         sp_q       <= sp_d;
         x_q        <= x_d;
         tok_q      <= tok_d;
         pow_base_q <= pow_base_d;
         pow_acc_q  <= pow_acc_d;
         pow_cnt_q  <= pow_cnt_d;
         err_pend_q <= err_pend_d;
         result_q   <= result_d;
         error_q    <= error_d;
         code_q     <= code_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_addr] <= push_val;
      end
   end

   assign queue_rd_index = idx_q;
   assign busy           = (state_q != StIdle) && (state_q != StDone);
   assign done           = state_q == StDone;
   assign result         = result_q;
   assign error          = error_q;
   assign error_code     = code_q;

endmodule
